sweep_ctrl: RTL and testbench

//   Frequency-sweep sequencer for the counter + dual-port sine ROM generator.
//   It drives the generator's en, incr and offset inputs.
//   It steps the phase increment from a start value to a stop value.

---
 rtl/sweep_ctrl.sv | 118 +++++++++++
 tb/tb_sweep_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: steps incr from start to stop, holding each value for a dwell time.
// Latency: start -> en/incr is 1 cycle. There is no backpressure: start is ignored while busy, and abort always wins.
module sweep_ctrl #(
    parameter int D_WIDTH = 8,
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               loop_mode,
    input  logic [D_WIDTH-1:0] cfg_start,
    input  logic [D_WIDTH-1:0] cfg_stop,
    input  logic [D_WIDTH-1:0] cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [7:0]         cfg_offset,
    output logic               en,
    output logic [D_WIDTH-1:0] incr,
    output logic [7:0]         offset,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sweep_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [D_WIDTH-1:0] sh_start, sh_stop, sh_step;
    logic [DWELL_W-1:0] sh_reload, dwell_cnt;
    logic               sh_loop;

    logic [D_WIDTH:0]   next_incr;
    logic               sweep_over;
    logic [DWELL_W-1:0] cfg_reload;

    // The extra carry bit makes an overflowing step compare as greater than stop.
    assign next_incr  = {1'b0, incr} + {1'b0, sh_step};
    assign sweep_over = (sh_step == '0) || (next_incr > {1'b0, sh_stop}) || (incr == sh_stop);
    assign cfg_reload = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            en        <= 1'b0;
            incr      <= '0;
            offset    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sweep_cnt <= '0;
            dwell_cnt <= '0;
            sh_start  <= '0;
            sh_stop   <= '0;
            sh_step   <= '0;
            sh_reload <= '0;
            sh_loop   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    en   <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start && !abort) begin
                        sh_start  <= cfg_start;
                        sh_stop   <= cfg_stop;
                        sh_step   <= cfg_step;
                        sh_reload <= cfg_reload;
                        sh_loop   <= loop_mode;
                        state     <= RUN;
                        en        <= 1'b1;
                        busy      <= 1'b1;
                        incr      <= cfg_start;
                        offset    <= cfg_offset;
                        dwell_cnt <= cfg_reload;
                        sweep_cnt <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end else if (!sweep_over) begin
                        incr      <= next_incr[D_WIDTH-1:0];
                        dwell_cnt <= sh_reload;
                    end else if (sh_loop) begin
                        incr      <= sh_start;
                        dwell_cnt <= sh_reload;
                        sweep_cnt <= sweep_cnt + CNT_W'(1);
                    end else begin
                        sweep_cnt <= sweep_cnt + CNT_W'(1);
                        state     <= DONE;
                        en        <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    // A single cycle; start is ignored here and abort has the same outcome.
                    state <= IDLE;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: a per-sweep sequence model checked every cycle, plus literal pins on key sweeps.
module tb_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, loop_mode = 1'b0;
    logic [7:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0, cfg_offset = '0;
    logic [15:0] cfg_dwell = '0;
    logic       en, busy, done;
    logic [7:0] incr, offset, sweep_cnt;

    int checks = 0;
    int failures = 0;

    sweep_ctrl #(.D_WIDTH(8), .DWELL_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_mode(loop_mode),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .cfg_dwell(cfg_dwell), .cfg_offset(cfg_offset),
        .en(en), .incr(incr), .offset(offset), .busy(busy), .done(done),
        .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    // Model: the whole sweep is expanded into a queue of incr values, one entry per cycle.
    int m_state = 0;  // 0 idle, 1 run, 2 done
    int m_en = 0, m_incr = 0, m_offset = 0, m_busy = 0, m_done = 0, m_cnt = 0;
    int s_start, s_stop, s_step, s_dwell, s_loop;
    int seq[$];

    task automatic build_seq();
        int v;
        seq.delete();
        v = s_start;
        forever begin
            for (int k = 0; k < ((s_dwell == 0) ? 1 : s_dwell); k++) seq.push_back(v);
            if (s_step == 0 || v + s_step > s_stop || v == s_stop) break;
            v = v + s_step;
        end
    endtask

    logic c_start, c_abort, c_loop, c_rst;
    logic [7:0] c_cstart, c_cstop, c_cstep, c_coff;
    logic [15:0] c_dwell;

    always begin
        @(posedge clk);
        c_rst = rst; c_start = start; c_abort = abort; c_loop = loop_mode;
        c_cstart = cfg_start; c_cstop = cfg_stop; c_cstep = cfg_step;
        c_coff = cfg_offset; c_dwell = cfg_dwell;
        #1;
        if (c_rst || rst) begin
            m_state = 0; m_en = 0; m_incr = 0; m_offset = 0; m_busy = 0; m_done = 0; m_cnt = 0;
        end else begin
            case (m_state)
                0: begin
                    m_en = 0; m_busy = 0; m_done = 0;
                    if (c_start && !c_abort) begin
                        s_start = c_cstart; s_stop = c_cstop; s_step = c_cstep;
                        s_dwell = c_dwell; s_loop = c_loop;
                        build_seq();
                        m_incr = seq.pop_front();
                        m_offset = c_coff; m_cnt = 0;
                        m_state = 1; m_en = 1; m_busy = 1;
                    end
                end
                1: begin
                    if (c_abort) begin
                        m_state = 0; m_en = 0; m_busy = 0; m_done = 0;
                    end else if (seq.size() > 0) begin
                        m_incr = seq.pop_front();
                    end else begin
                        m_cnt = (m_cnt + 1) % 256;
                        if (s_loop != 0) begin
                            build_seq();
                            m_incr = seq.pop_front();
                        end else begin
                            m_state = 2; m_en = 0; m_busy = 0; m_done = 1;
                        end
                    end
                end
                default: begin
                    m_state = 0; m_en = 0; m_busy = 0; m_done = 0;
                end
            endcase
        end
        check("en", en, m_en);
        check("incr", incr, m_incr);
        check("offset", offset, m_offset);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("sweep_cnt", sweep_cnt, m_cnt);
    end

    int rec[$];

    task automatic set_cfg(input int st, input int sp, input int stp, input int dw, input int lp);
        cfg_start = st[7:0]; cfg_stop = sp[7:0]; cfg_step = stp[7:0];
        cfg_dwell = dw[15:0]; loop_mode = lp[0]; cfg_offset = 8'h40;
    endtask

    task automatic go();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Records incr for n cycles starting with the current one; optionally disturbs cfg inputs and start mid-run.
    task automatic sample_run(input int n, input bit disturb);
        rec.delete();
        rec.push_back(incr);
        for (int i = 1; i < n; i++) begin
            if (disturb && i == 1) begin
                start = 1'b1; cfg_start = 8'd77; cfg_stop = 8'd90; cfg_step = 8'd5;
                cfg_dwell = 16'd9; loop_mode = 1'b1; cfg_offset = 8'h11;
            end
            @(posedge clk);
            #1;
            if (disturb && i == 2) start = 1'b0;
            rec.push_back(incr);
        end
    endtask

    task automatic expect_done(input string nm, input int fin);
        @(posedge clk);
        #1;
        check({nm, "_done"}, done, 1);
        check({nm, "_en_off"}, en, 0);
        check({nm, "_final"}, incr, fin);
        check({nm, "_cnt"}, sweep_cnt, 1);
        @(posedge clk);
        #1;
        check({nm, "_done_clr"}, done, 0);
    endtask

    int t1[12] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4};
    int pat[6] = '{2, 2, 4, 4, 6, 6};

    initial begin
        #1;
        check("rst_en", en, 0); check("rst_incr", incr, 0); check("rst_busy", busy, 0);
        check("rst_cnt", sweep_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // One-shot 1..4, dwell 3
        set_cfg(1, 4, 1, 3, 0);
        go();
        check("t1_offset", offset, 8'h40);
        sample_run(12, 1'b0);
        for (int i = 0; i < 12; i++) check("t1_seq", rec[i], t1[i]);
        expect_done("t1", 4);
        check("t1_busy", busy, 0);

        // Overshoot and carry
        set_cfg(10, 20, 4, 1, 0);
        go();
        sample_run(3, 1'b0);
        check("t2_v0", rec[0], 10); check("t2_v1", rec[1], 14); check("t2_v2", rec[2], 18);
        expect_done("t2", 18);
        set_cfg(250, 255, 8, 1, 0);
        go();
        check("t2b_v0", incr, 250);
        expect_done("t2b", 250);

        // Loop mode
        set_cfg(2, 6, 2, 2, 1);
        go();
        sample_run(20, 1'b0);
        for (int i = 0; i < 20; i++) check("t3_seq", rec[i], pat[i % 6]);
        check("t3_cnt", sweep_cnt, 3);
        check("t3_nodone", done, 0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("t3_abort_busy", busy, 0);
        check("t3_abort_cnt", sweep_cnt, 3);

        // Abort at incr==3
        set_cfg(1, 10, 1, 2, 0);
        go();
        for (int i = 0; i < 50 && incr != 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("t4_reach3", incr, 3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("t4_en", en, 0); check("t4_busy", busy, 0); check("t4_done", done, 0);
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        check("t4_startabort_busy", busy, 0);

        // Edge settings
        set_cfg(5, 7, 1, 0, 0);
        go();
        sample_run(3, 1'b0);
        check("t5_d0_v0", rec[0], 5); check("t5_d0_v1", rec[1], 6); check("t5_d0_v2", rec[2], 7);
        expect_done("t5d0", 7);
        set_cfg(9, 20, 0, 2, 0);
        go();
        sample_run(2, 1'b0);
        check("t5_s0_v0", rec[0], 9); check("t5_s0_v1", rec[1], 9);
        expect_done("t5s0", 9);
        set_cfg(1, 3, 1, 2, 0);
        go();
        sample_run(6, 1'b1);
        for (int i = 0; i < 6; i++) check("t5_dist_seq", rec[i], 1 + i / 2);
        check("t5_dist_off", offset, 8'h40);
        expect_done("t5dist", 3);

        // Async reset mid-run
        set_cfg(1, 4, 1, 3, 0);
        go();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_en", en, 0); check("t6_incr", incr, 0); check("t6_off", offset, 0);
        check("t6_busy", busy, 0); check("t6_done", done, 0); check("t6_cnt", sweep_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_cfg(1, 4, 1, 3, 0);
        go();
        sample_run(12, 1'b0);
        for (int i = 0; i < 12; i++) check("t6_seq", rec[i], t1[i]);
        expect_done("t6", 4);

        // Randomized traffic; the per-cycle model carries the checking
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            cfg_start = 8'($urandom_range(0, 255));
            cfg_stop = 8'($urandom_range(0, 255));
            cfg_step = ($urandom % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 80));
            cfg_dwell = 16'($urandom_range(0, 3));
            cfg_offset = 8'($urandom);
            loop_mode = ($urandom % 3 == 0);
            start = ($urandom % 6 == 0);
            abort = ($urandom % 70 == 0);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
